// File: rtl/wash_pkg.sv
// Shared types and encodings for the washing-machine controller: state
// encoding, program codes, motor codes and program-decode helpers.
package wash_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FILL      = 4'd1,
        ST_WAIT_SOAP = 4'd2,
        ST_WASH      = 4'd3,
        ST_DRAIN_W   = 4'd4,
        ST_RINSE     = 4'd5,
        ST_DRAIN_R   = 4'd6,
        ST_SPIN      = 4'd7,
        ST_PAUSED    = 4'd8,
        ST_DONE      = 4'd9
    } wash_state_e;

    localparam logic [2:0] PRG_COLD  = 3'b000;
    localparam logic [2:0] PRG_HOT   = 3'b001;
    localparam logic [2:0] PRG_WARM  = 3'b100;
    localparam logic [2:0] PRG_RINSE = 3'b010;
    localparam logic [2:0] PRG_SPIN  = 3'b011;

    localparam logic [1:0] MOTOR_OFF     = 2'b00;
    localparam logic [1:0] MOTOR_AGITATE = 2'b01;
    localparam logic [1:0] MOTOR_SPIN    = 2'b10;

    function automatic logic prg_valid(input logic [2:0] prg);
        logic ok;
        case (prg)
            PRG_COLD, PRG_HOT, PRG_WARM, PRG_RINSE, PRG_SPIN: ok = 1'b1;
            default:                                          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic wash_state_e first_phase(input logic [2:0] prg);
        wash_state_e st;
        case (prg)
            PRG_RINSE: st = ST_RINSE;
            PRG_SPIN:  st = ST_SPIN;
            default:   st = ST_FILL;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter for phase timing; load beats hold, and the count
// parks at zero instead of wrapping.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             hold_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load, hold, or decrement toward zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (hold_i) begin
            count_d = count_q;
        end else if (count_q != {CNT_W{1'b0}}) begin
            count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine cycle controller: sequences fill/wash/drain/rinse/spin with
// pause/resume, door-fault and power-loss handling and a per-phase countdown.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int FILL_T     = 8,
    parameter int WASH_T     = 12,
    parameter int DRAIN_T    = 8,
    parameter int RINSE_T    = 9,
    parameter int SPIN_T     = 12,
    parameter int MAX_RINSES = 3,
    parameter int RC_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             power_i,
    input  logic             start_i,
    input  logic             pause_i,
    input  logic             door_closed_i,
    input  logic             soap_i,
    input  logic [2:0]       program_i,
    input  logic [RC_W-1:0]  rinse_count_i,
    output logic             valve_cold_o,
    output logic             valve_hot_o,
    output logic             valve_out_o,
    output logic             soap_in_o,
    output logic [1:0]       motor_o,
    output logic             lock_door_o,
    output logic             soap_warning_o,
    output logic             door_fault_o,
    output logic [CNT_W-1:0] phase_left_o,
    output logic [3:0]       rinses_left_o,
    output logic             busy_o,
    output logic             program_done_o
);

    localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_T - 1);
    localparam logic [CNT_W-1:0] WASH_LD  = CNT_W'(WASH_T - 1);
    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_T - 1);
    localparam logic [CNT_W-1:0] RINSE_LD = CNT_W'(RINSE_T - 1);
    localparam logic [CNT_W-1:0] SPIN_LD  = CNT_W'(SPIN_T - 1);

    wash_state_e      state_q, state_d;
    wash_state_e      saved_q, saved_d;
    logic [2:0]       prog_q, prog_d;
    logic [3:0]       rinses_q, rinses_d;
    logic             fault_q, fault_d;

    logic             tmr_load_s;
    logic             tmr_hold_s;
    logic [CNT_W-1:0] tmr_val_s;
    logic             tmr_zero_s;
    logic [CNT_W-1:0] tmr_count_s;
    logic [3:0]       rc_clamp_s;

    logic             cold_d, hot_d, out_d, soap_in_d, warn_d, lock_d, busy_d, done_d;
    logic [1:0]       motor_d;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load_s),
        .hold_i     (tmr_hold_s),
        .load_val_i (tmr_val_s),
        .count_o    (tmr_count_s),
        .zero_o     (tmr_zero_s)
    );

    // Requested rinse passes, clamped; rinse+spin always runs at least one.
    always_comb begin
        if (int'(rinse_count_i) > MAX_RINSES) begin
            rc_clamp_s = 4'(MAX_RINSES);
        end else begin
            rc_clamp_s = 4'(rinse_count_i);
        end
        if ((program_i == PRG_RINSE) && (rc_clamp_s == 4'd0)) begin
            rc_clamp_s = 4'd1;
        end else begin
            rc_clamp_s = rc_clamp_s;
        end
    end

    // State and latched cycle context.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            saved_q  <= ST_IDLE;
            prog_q   <= 3'b000;
            rinses_q <= 4'd0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            saved_q  <= saved_d;
            prog_q   <= prog_d;
            rinses_q <= rinses_d;
            fault_q  <= fault_d;
        end
    end

    // Next state; any edge that pauses, waits or resumes freezes the timer.
    always_comb begin
        state_d    = state_q;
        saved_d    = saved_q;
        prog_d     = prog_q;
        rinses_d   = rinses_q;
        fault_d    = fault_q;
        tmr_load_s = 1'b0;
        tmr_hold_s = 1'b0;
        if (!power_i) begin
            state_d    = ST_IDLE;
            saved_d    = ST_IDLE;
            prog_d     = 3'b000;
            rinses_d   = 4'd0;
            fault_d    = 1'b0;
            tmr_load_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tmr_load_s = 1'b1;
                    if (start_i && door_closed_i && prg_valid(program_i)) begin
                        state_d  = first_phase(program_i);
                        prog_d   = program_i;
                        rinses_d = rc_clamp_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state_d    = ST_IDLE;
                    saved_d    = ST_IDLE;
                    prog_d     = 3'b000;
                    rinses_d   = 4'd0;
                    tmr_load_s = 1'b1;
                end
                ST_PAUSED: begin
                    tmr_hold_s = 1'b1;
                    if (start_i && door_closed_i && !pause_i) begin
                        state_d = saved_q;
                        fault_d = 1'b0;
                    end else begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_FILL, ST_WAIT_SOAP, ST_WASH, ST_DRAIN_W,
                ST_RINSE, ST_DRAIN_R, ST_SPIN: begin
                    if (!door_closed_i) begin
                        state_d    = ST_PAUSED;
                        saved_d    = state_q;
                        fault_d    = 1'b1;
                        tmr_hold_s = 1'b1;
                    end else if (pause_i) begin
                        state_d    = ST_PAUSED;
                        saved_d    = state_q;
                        tmr_hold_s = 1'b1;
                    end else if (state_q == ST_WAIT_SOAP) begin
                        tmr_hold_s = 1'b1;
                        state_d    = soap_i ? ST_FILL : ST_WAIT_SOAP;
                    end else if ((state_q == ST_FILL) && !soap_i) begin
                        state_d    = ST_WAIT_SOAP;
                        tmr_hold_s = 1'b1;
                    end else if (tmr_zero_s) begin
                        tmr_load_s = 1'b1;
                        case (state_q)
                            ST_FILL:    state_d = ST_WASH;
                            ST_WASH:    state_d = ST_DRAIN_W;
                            ST_DRAIN_W: state_d = (rinses_q != 4'd0) ? ST_RINSE : ST_SPIN;
                            ST_RINSE:   state_d = ST_DRAIN_R;
                            ST_DRAIN_R: begin
                                rinses_d = (rinses_q != 4'd0) ? (rinses_q - 4'd1) : 4'd0;
                                state_d  = (rinses_q > 4'd1) ? ST_RINSE : ST_SPIN;
                            end
                            ST_SPIN:    state_d = ST_DONE;
                            default:    state_d = ST_IDLE;
                        endcase
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    saved_d    = ST_IDLE;
                    prog_d     = 3'b000;
                    rinses_d   = 4'd0;
                    fault_d    = 1'b0;
                    tmr_load_s = 1'b1;
                end
            endcase
        end
    end

    // Phase length for whichever phase is being entered.
    always_comb begin
        case (state_d)
            ST_FILL:               tmr_val_s = FILL_LD;
            ST_WASH:               tmr_val_s = WASH_LD;
            ST_DRAIN_W, ST_DRAIN_R: tmr_val_s = DRAIN_LD;
            ST_RINSE:              tmr_val_s = RINSE_LD;
            ST_SPIN:               tmr_val_s = SPIN_LD;
            default:               tmr_val_s = {CNT_W{1'b0}};
        endcase
    end

    // Actuator decode from the next state so the registered outputs line up
    // with the state register.
    always_comb begin
        cold_d    = 1'b0;
        hot_d     = 1'b0;
        out_d     = 1'b0;
        soap_in_d = 1'b0;
        warn_d    = 1'b0;
        motor_d   = MOTOR_OFF;
        case (state_d)
            ST_FILL: begin
                cold_d    = (prog_d == PRG_COLD) || (prog_d == PRG_WARM);
                hot_d     = (prog_d == PRG_HOT)  || (prog_d == PRG_WARM);
                soap_in_d = 1'b1;
            end
            ST_WASH:                motor_d = MOTOR_AGITATE;
            ST_DRAIN_W, ST_DRAIN_R: out_d   = 1'b1;
            ST_RINSE:               cold_d  = 1'b1;
            ST_SPIN: begin
                motor_d = MOTOR_SPIN;
                out_d   = 1'b1;
            end
            ST_WAIT_SOAP:           warn_d  = 1'b1;
            default:                motor_d = MOTOR_OFF;
        endcase
        lock_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valve_cold_o   <= 1'b0;
            valve_hot_o    <= 1'b0;
            valve_out_o    <= 1'b0;
            soap_in_o      <= 1'b0;
            motor_o        <= MOTOR_OFF;
            lock_door_o    <= 1'b0;
            soap_warning_o <= 1'b0;
            busy_o         <= 1'b0;
            program_done_o <= 1'b0;
        end else begin
            valve_cold_o   <= cold_d;
            valve_hot_o    <= hot_d;
            valve_out_o    <= out_d;
            soap_in_o      <= soap_in_d;
            motor_o        <= motor_d;
            lock_door_o    <= lock_d;
            soap_warning_o <= warn_d;
            busy_o         <= busy_d;
            program_done_o <= done_d;
        end
    end

    assign door_fault_o  = fault_q;
    assign rinses_left_o = rinses_q;
    assign phase_left_o  = tmr_count_s;

endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Parametrised second-generation washing-machine controller that sequences fill, wash, drain, a programmable number of rinse/drain passes and a final spin. It adds pause/resume, a door-fault response, a power-loss abort and a per-phase countdown output. It sits between the front-panel inputs and the valve/motor/door actuators, and is the single controller instance in the machine top level.

## Interface

- CNT_W, 8: phase timer and countdown width.
- FILL_T, 8: fill phase length, cycles. Legal range 1..2^CNT_W-1; the same range applies to every *_T parameter.
- WASH_T, 12: wash-agitate phase length, cycles.
- DRAIN_T, 8: drain phase length, cycles.
- RINSE_T, 9: rinse-fill phase length, cycles.
- SPIN_T, 12: spin phase length, cycles.
- MAX_RINSES, 3: upper clamp on rinse passes. Legal range 1..15.
- RC_W, 4: width of rinse_count.
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- power, input, 1: mains enable. Low aborts any cycle.
- start, input, 1: level. Starts a cycle from IDLE; resumes from PAUSED.
- pause, input, 1: level. Requests a pause while active.
- door_closed, input, 1: door sensor.
- soap, input, 1: detergent present.
- program, input, 3: program code, decoded below.
- rinse_count, input, RC_W: requested rinse passes.
- valve_cold, output, 1: cold inlet valve.
- valve_hot, output, 1: hot inlet valve.
- valve_out, output, 1: drain valve.
- soap_in, output, 1: detergent dispense.
- motor, output, 2: 00 off, 01 agitate, 10 spin.
- lock_door, output, 1: door latch.
- soap_warning, output, 1: soap is missing.
- door_fault, output, 1: door opened mid-cycle.
- phase_left, output, CNT_W: cycles remaining in the current phase.
- rinses_left, output, 4: rinse passes still to run.
- busy, output, 1: controller is in any state other than IDLE.
- program_done, output, 1: one-cycle completion pulse.

## Operation

- Program codes: 000 cold wash; 001 hot wash; 100 warm wash (both inlet valves); 010 rinse+spin; 011 spin only. Other codes are ignored and the controller stays in IDLE.
- States: IDLE, FILL, WAIT_SOAP, WASH, DRAIN_W, RINSE, DRAIN_R, SPIN, PAUSED, DONE.
- Leaving IDLE requires power, start and door_closed together.
  - Wash programs go to FILL.
  - 010 goes to RINSE.
  - 011 goes to SPIN.
- Latching on that IDLE exit:
  - program is latched.
  - rinse_count is latched, then clamped to MAX_RINSES.
  - For program 010, a latched value of 0 becomes 1.
- Phase sequence:
  - FILL, then WASH, then DRAIN_W.
  - After DRAIN_W: RINSE if rinses_left>0, otherwise SPIN.
  - RINSE, then DRAIN_R. rinses_left decrements on DRAIN_R exit.
  - After DRAIN_R: RINSE if rinses_left is still >0, otherwise SPIN.
  - SPIN, then DONE, then IDLE.
- FILL with soap low goes to WAIT_SOAP; phase_left is frozen. When soap rises, the controller returns to FILL and resumes the count.
- Outputs per state:
  - FILL: inlet valve(s) per program, plus soap_in.
  - WASH: motor 01.
  - DRAIN_W and DRAIN_R: valve_out.
  - RINSE: valve_cold.
  - SPIN: motor 10 and valve_out.
  - WAIT_SOAP: soap_warning.
  - Every other output is 0 in every state.
- lock_door is 1 in every state except IDLE and DONE, including PAUSED.
- pause while active (any state except IDLE and DONE) goes to PAUSED. The interrupted state and phase_left are saved; all actuators are off.
- door_closed low in any active state except PAUSED goes to PAUSED with door_fault set. In PAUSED, door_fault is 0 only once the door has closed and the controller has resumed.
- Resume from PAUSED requires start, door_closed and pause low. The controller re-enters the saved state with phase_left unchanged. door_fault clears on resume.
- power low in any state goes to IDLE on the next edge. All latches and door_fault clear; program_done is not asserted.
- Priority, highest first: power loss, door fault, pause, soap wait, phase expiry.

## Timing

- Reset values: every output 0, state IDLE, phase_left 0, rinses_left 0.
- The start edge, sampled in IDLE, puts the controller in the first phase on the next cycle.
- A phase of length T occupies exactly T active cycles.
  - On entry phase_left = T-1; it decrements each active cycle.
  - The transition happens at the edge where phase_left==0.
  - Cycles spent in PAUSED or WAIT_SOAP do not count.
- DONE lasts 1 cycle. program_done=1 only in DONE.
- Cold wash with 1 rinse and no pauses: FILL+WASH+DRAIN+RINSE+DRAIN+SPIN+1 = 58 cycles from leaving IDLE to returning to IDLE.
- pause and phase expiry on the same edge: PAUSED wins. The saved state is the one being exited, with phase_left 0, so the transition completes one active cycle after resume.
- An asynchronous rst mid-cycle returns everything to reset values immediately.

## Structure

- Package wash_pkg holds:
  - the state enum (4-bit encoding);
  - the program codes;
  - the motor codes.
- Sub-module phase_timer is a loadable CNT_W down-counter with load, hold and zero flag. It is instantiated once.

## Test plan

- Reset, then program=000, rinse_count=1, start for 1 cycle with soap and door high -> states run FILL(8), WASH(12), DRAIN_W(8), RINSE(9), DRAIN_R(8), SPIN(12); program_done pulses at cycle 57; busy falls at 58.
- Program 001 with soap low -> WAIT_SOAP and soap_warning=1 with phase_left held at 7; raise soap after 20 cycles -> FILL resumes and valve_hot=1 for the 8 remaining active cycles.
- Pause at WASH with phase_left=5, hold 10 cycles, release, pulse start -> WASH resumes at 5; motor is 00 throughout the pause and lock_door stays 1.
- door_closed low during SPIN -> PAUSED with door_fault=1; start with the door still open -> controller stays PAUSED; close the door and start -> SPIN resumes and door_fault=0.
- Program 010 with rinse_count=7 and MAX_RINSES=3 -> exactly 3 RINSE/DRAIN_R pairs, rinses_left counting 3, 2, 1, 0.
- power low mid-RINSE -> IDLE on the next cycle with all outputs 0; program 111 with start -> controller stays IDLE.
